wb_arb: RTL

WB_ARB -- requirements
Module: wb_arb

---
 rtl/wb_arb_if.sv | 29 ++
 rtl/wb_arb.sv | 102 ++++++++++
 2 files changed

// File: rtl/wb_arb_if.sv
// Write-back arbiter bus: MEM_WB pipeline source, long-latency unit source and the
// single register-file write port. slave = arbiter side, master = surrounding core.
interface wb_arb_if;
    logic        pipe_we_i_WB_ARB;
    logic [4:0]  pipe_addr_i_WB_ARB;
    logic [31:0] pipe_data_i_WB_ARB;
    logic        lu_valid_i_WB_ARB;
    logic [4:0]  lu_addr_i_WB_ARB;
    logic [31:0] lu_data_i_WB_ARB;
    logic        lu_ready_o_WB_ARB;
    logic        stall_o_WB_ARB;
    logic        wt_enable_o_WB_ARB;
    logic [4:0]  wt_addr_o_WB_ARB;
    logic [31:0] wt_data_o_WB_ARB;

    modport slave (
        input  pipe_we_i_WB_ARB, pipe_addr_i_WB_ARB, pipe_data_i_WB_ARB,
        input  lu_valid_i_WB_ARB, lu_addr_i_WB_ARB, lu_data_i_WB_ARB,
        output lu_ready_o_WB_ARB, stall_o_WB_ARB,
        output wt_enable_o_WB_ARB, wt_addr_o_WB_ARB, wt_data_o_WB_ARB
    );

    modport master (
        output pipe_we_i_WB_ARB, pipe_addr_i_WB_ARB, pipe_data_i_WB_ARB,
        output lu_valid_i_WB_ARB, lu_addr_i_WB_ARB, lu_data_i_WB_ARB,
        input  lu_ready_o_WB_ARB, stall_o_WB_ARB,
        input  wt_enable_o_WB_ARB, wt_addr_o_WB_ARB, wt_data_o_WB_ARB
    );
endinterface

// File: rtl/wb_arb.sv
// Register-file write-port arbiter: pipeline writes win unless a buffered long-latency
// result has starved for STARVE_LIMIT cycles. Define WB_ARB_PERF_EN for conflict counting.
module wb_arb #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk_i_WB_ARB,
    input  logic         rst_i_WB_ARB,
    wb_arb_if.slave      bus
`ifdef WB_ARB_PERF_EN
    ,
    output logic [15:0]  conflict_cnt_o_WB_ARB
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [2:0]    count;
    logic [3:0]    wait_cnt;

    logic        pipe_active;
    logic        not_empty;
    logic        stall;
    logic        grant_pipe;
    logic        pop;
    logic        push;
    logic        ready;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_addr   = addr_mem[rd_ptr];
    assign head_data   = data_mem[rd_ptr];
    assign pipe_active = bus.pipe_we_i_WB_ARB && (bus.pipe_addr_i_WB_ARB != 5'd0);
    // Emptiness comes from the registered count, so a fresh push is only poppable next cycle.
    assign not_empty   = (count != 3'd0);
    assign stall       = not_empty && (wait_cnt == 4'(STARVE_LIMIT));
    assign grant_pipe  = pipe_active && !stall;
    assign pop         = not_empty && !grant_pipe;
    assign ready       = (count < 3'(DEPTH));
    assign push        = bus.lu_valid_i_WB_ARB && ready;

    assign bus.lu_ready_o_WB_ARB = ready;
    assign bus.stall_o_WB_ARB    = stall;

    always_ff @(posedge clk_i_WB_ARB) begin
        if (push) begin
            addr_mem[wr_ptr] <= bus.lu_addr_i_WB_ARB;
            data_mem[wr_ptr] <= bus.lu_data_i_WB_ARB;
        end
    end

    always_ff @(posedge clk_i_WB_ARB or negedge rst_i_WB_ARB) begin
        if (!rst_i_WB_ARB) begin
            rd_ptr                 <= '0;
            wr_ptr                 <= '0;
            count                  <= 3'd0;
            wait_cnt               <= 4'd0;
            bus.wt_enable_o_WB_ARB <= 1'b0;
            bus.wt_addr_o_WB_ARB   <= 5'd0;
            bus.wt_data_o_WB_ARB   <= 32'd0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + {2'b00, push} - {2'b00, pop};

            if (pop || !not_empty)
                wait_cnt <= 4'd0;
            else if (wait_cnt != 4'(STARVE_LIMIT))
                wait_cnt <= wait_cnt + 4'd1;

            // A popped head with destination r0 is consumed silently.
            bus.wt_enable_o_WB_ARB <= grant_pipe || (pop && (head_addr != 5'd0));
            if (grant_pipe) begin
                bus.wt_addr_o_WB_ARB <= bus.pipe_addr_i_WB_ARB;
                bus.wt_data_o_WB_ARB <= bus.pipe_data_i_WB_ARB;
            end else if (pop) begin
                bus.wt_addr_o_WB_ARB <= head_addr;
                bus.wt_data_o_WB_ARB <= head_data;
            end
        end
    end

`ifdef WB_ARB_PERF_EN
    logic [15:0] conflict_cnt;

    always_ff @(posedge clk_i_WB_ARB or negedge rst_i_WB_ARB) begin
        if (!rst_i_WB_ARB)
            conflict_cnt <= 16'd0;
        else if (not_empty && pipe_active && (conflict_cnt != 16'hFFFF))
            conflict_cnt <= conflict_cnt + 16'd1;
    end

    assign conflict_cnt_o_WB_ARB = conflict_cnt;
`endif
endmodule
